ysyx_25040118_exu_mc: RTL and testbench

Multi-cycle execute unit, next generation of the single-cycle EXU. Takes one decoded instruction per valid/ready handshake from the IDU and computes ALU, branch/jump, load/store and optional RV32M results. Memory goes through a latency-tolerant request/response bus instead of combinational DPI reads, with byte-lane alignment. Results are handed to the WBU through a valid/ready handshake.

---
 rtl/ysyx_25040118_exu_mc.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_ysyx_25040118_exu_mc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040118_exu_mc.sv
// Multi-cycle execute unit: ALU/branch/jump in one step, memory over a req/rsp bus,
// iterative RV32M, result handed to the WBU over a valid/ready handshake.
module ysyx_25040118_exu_mc #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  MEM_BASE = 'h8000_0000,
    parameter bit               EN_MDU   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   src1,
    input  logic [XLEN-1:0]   src2,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   inst,
    input  logic [4:0]        alu_ctrl,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              is_branch,
    input  logic              is_jal,
    input  logic              is_jalr,
    input  logic              is_auipc,
    input  logic              is_lui,
    input  logic              is_alu_imm,
    input  logic              is_mdu,
    input  logic              ebreak,
    input  logic [2:0]        mdu_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [XLEN-1:0]   out_next_pc,
    output logic              out_ebreak,
    output logic              out_misalign,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int LW    = $clog2(NB);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, MDU_BUSY, DONE} state_t;

    state_t              state_reg;
    logic                out_valid_reg;
    logic [XLEN-1:0]     result_reg;
    logic [XLEN-1:0]     next_pc_reg;
    logic                ebreak_reg;
    logic                misalign_reg;
    logic                req_valid_reg;
    logic                req_we_reg;
    logic [XLEN-1:0]     req_addr_reg;
    logic [XLEN-1:0]     req_wdata_reg;
    logic [NB-1:0]       req_wmask_reg;
    logic [2:0]          funct3_reg;
    logic [LW-1:0]       ea_lo_reg;
    logic                is_load_reg;

    logic [2*XLEN-1:0]   prod_reg;
    logic [2*XLEN-1:0]   mcand_reg;
    logic [XLEN-1:0]     mplier_reg;
    logic [XLEN:0]       rem_reg;
    logic [XLEN-1:0]     quot_reg;
    logic [XLEN-1:0]     divisor_reg;
    logic [XLEN-1:0]     src1_reg;
    logic [2:0]          mdu_op_reg;
    logic                neg_prod_reg;
    logic                neg_rem_reg;
    logic                div_zero_reg;
    logic [CNT_W-1:0]    cnt_reg;

    // ---------------- accept-time datapath (from the raw inputs) ----------------
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_b;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] ea;
    logic            br_taken;
    logic            misalign;
    logic [NB-1:0]   base_mask;
    logic [XLEN-1:0] acc_result;
    logic [XLEN-1:0] acc_next_pc;
    logic            unused_ok;

    assign funct3      = inst[14:12];
    assign op_b        = is_alu_imm ? imm : src2;
    assign shamt       = op_b[SH_W-1:0];
    assign pc_plus4    = pc + XLEN'(4);
    assign pc_plus_imm = pc + imm;
    assign ea          = src1 + imm;
    assign unused_ok   = ^{inst[XLEN-1:15], inst[11:0]};

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            5'b00000: alu_res = src1 + op_b;
            5'b10000: alu_res = src1 - op_b;
            5'b00001: alu_res = src1 << shamt;
            5'b00101: alu_res = src1 >> shamt;
            5'b00110: alu_res = $signed(src1) >>> shamt;
            5'b00010: alu_res = XLEN'($signed(src1) < $signed(op_b));
            5'b00011: alu_res = XLEN'(src1 < op_b);
            5'b00100: alu_res = src1 ^ op_b;
            5'b00111: alu_res = src1 | op_b;
            5'b01000: alu_res = src1 & op_b;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (src1 == src2);
            3'b001:  br_taken = (src1 != src2);
            3'b100:  br_taken = ($signed(src1) <  $signed(src2));
            3'b101:  br_taken = ($signed(src1) >= $signed(src2));
            3'b110:  br_taken = (src1 <  src2);
            3'b111:  br_taken = (src1 >= src2);
            default: br_taken = 1'b0;
        endcase
    end

    assign misalign = (is_load | is_store) &&
                      ((funct3[1:0] == 2'b01 && ea[0]) ||
                       (funct3[1:0] == 2'b10 && ea[1:0] != 2'b00));

    always_comb begin
        base_mask = '1;
        case (funct3[1:0])
            2'b00:   base_mask = NB'(1);
            2'b01:   base_mask = NB'(3);
            default: base_mask = '1;
        endcase
    end

    // Memory ops, mdu ops and ebreak carry no accept-time result.
    always_comb begin
        acc_result  = alu_res;
        acc_next_pc = pc_plus4;
        if (is_lui) begin
            acc_result = imm;
        end else if (is_auipc) begin
            acc_result = pc_plus_imm;
        end else if (is_jal) begin
            acc_result  = pc_plus4;
            acc_next_pc = pc_plus_imm;
        end else if (is_jalr) begin
            acc_result  = pc_plus4;
            acc_next_pc = {ea[XLEN-1:1], 1'b0};
        end else if (is_branch) begin
            acc_result  = '0;
            acc_next_pc = br_taken ? pc_plus_imm : pc_plus4;
        end else if (is_load | is_store | is_mdu | ebreak) begin
            acc_result = '0;
        end
    end

    // ---------------- load alignment / extension ----------------
    logic [XLEN-1:0] ld_word;
    logic [XLEN-1:0] ld_value;

    assign ld_word = mem_rsp_rdata >> {ea_lo_reg, 3'b000};

    always_comb begin
        ld_value = '0;
        case (funct3_reg)
            3'b000:  ld_value = {{(XLEN-8){ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_value = {{(XLEN-16){ld_word[15]}}, ld_word[15:0]};
            3'b010:  ld_value = ld_word;
            3'b100:  ld_value = {{(XLEN-8){1'b0}}, ld_word[7:0]};
            3'b101:  ld_value = {{(XLEN-16){1'b0}}, ld_word[15:0]};
            default: ld_value = '0;
        endcase
    end

    // ---------------- iterative multiply / divide ----------------
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    assign a_sgn = src1[XLEN-1] && (mdu_op == 3'd1 || mdu_op == 3'd2 ||
                                    mdu_op == 3'd4 || mdu_op == 3'd6);
    assign b_sgn = src2[XLEN-1] && (mdu_op == 3'd1 || mdu_op == 3'd4 || mdu_op == 3'd6);
    assign a_mag = a_sgn ? -src1 : src1;
    assign b_mag = b_sgn ? -src2 : src2;

    logic [2*XLEN-1:0] mul_sum;
    logic [2*XLEN-1:0] mul_fix;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic              div_ge;
    logic [XLEN:0]     rem_next;
    logic [XLEN-1:0]   quot_next;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   mdu_result;

    assign mul_sum   = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign div_shift = {rem_reg[XLEN-1:0], quot_reg[XLEN-1]};
    assign div_trial = div_shift - {1'b0, divisor_reg};
    assign div_ge    = ~div_trial[XLEN];
    assign rem_next  = div_ge ? div_trial : div_shift;
    assign quot_next = {quot_reg[XLEN-2:0], div_ge};

    // 0x8000_0000 / -1 falls out naturally: magnitude quotient 0x8000_0000 negates to itself.
    assign mul_fix  = neg_prod_reg ? -mul_sum : mul_sum;
    assign quot_fix = neg_prod_reg ? -quot_next : quot_next;
    assign rem_fix  = neg_rem_reg ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];

    always_comb begin
        mdu_result = '0;
        case (mdu_op_reg)
            3'd0:         mdu_result = mul_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:         mdu_result = mul_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:   mdu_result = div_zero_reg ? '1 : quot_fix;
            default:      mdu_result = div_zero_reg ? src1_reg : rem_fix;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            next_pc_reg   <= '0;
            ebreak_reg    <= 1'b0;
            misalign_reg  <= 1'b0;
            req_valid_reg <= 1'b0;
            req_we_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
            req_wmask_reg <= '0;
            funct3_reg    <= '0;
            ea_lo_reg     <= '0;
            is_load_reg   <= 1'b0;
            prod_reg      <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            rem_reg       <= '0;
            quot_reg      <= '0;
            divisor_reg   <= '0;
            src1_reg      <= '0;
            mdu_op_reg    <= '0;
            neg_prod_reg  <= 1'b0;
            neg_rem_reg   <= 1'b0;
            div_zero_reg  <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        result_reg   <= acc_result;
                        next_pc_reg  <= acc_next_pc;
                        ebreak_reg   <= ebreak;
                        misalign_reg <= misalign;
                        funct3_reg   <= funct3;
                        ea_lo_reg    <= ea[LW-1:0];
                        is_load_reg  <= is_load;
                        src1_reg     <= src1;
                        if ((is_load | is_store) && !misalign) begin
                            req_valid_reg <= 1'b1;
                            req_we_reg    <= is_store;
                            req_addr_reg  <= ea - MEM_BASE;
                            req_wdata_reg <= is_store ? (src2 << {ea[LW-1:0], 3'b000}) : '0;
                            req_wmask_reg <= is_store ? NB'(base_mask << ea[LW-1:0]) : '0;
                            state_reg     <= MEM_REQ;
                        end else if (is_mdu && EN_MDU) begin
                            prod_reg     <= '0;
                            mcand_reg    <= {{XLEN{1'b0}}, a_mag};
                            mplier_reg   <= b_mag;
                            rem_reg      <= '0;
                            quot_reg     <= a_mag;
                            divisor_reg  <= b_mag;
                            mdu_op_reg   <= mdu_op;
                            neg_prod_reg <= a_sgn ^ b_sgn;
                            neg_rem_reg  <= a_sgn;
                            div_zero_reg <= (src2 == '0);
                            cnt_reg      <= '0;
                            state_reg    <= MDU_BUSY;
                        end else begin
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // A store's response is only its write acknowledge.
                    if (mem_rsp_valid) begin
                        result_reg    <= is_load_reg ? ld_value : '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                MDU_BUSY: begin
                    prod_reg   <= mul_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    rem_reg    <= rem_next;
                    quot_reg   <= quot_next;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(XLEN - 1)) begin
                        result_reg    <= mdu_result;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state_reg == IDLE);
    assign out_valid     = out_valid_reg;
    assign out_result    = result_reg;
    assign out_next_pc   = next_pc_reg;
    assign out_ebreak    = ebreak_reg;
    assign out_misalign  = misalign_reg;
    assign mem_req_valid = req_valid_reg;
    assign mem_req_we    = req_we_reg;
    assign mem_req_addr  = req_addr_reg;
    assign mem_req_wdata = req_wdata_reg;
    assign mem_req_wmask = req_wmask_reg;

endmodule

// File: tb/tb_ysyx_25040118_exu_mc.sv
// Directed bench for the multi-cycle EXU: ALU, loads/stores with bus stalls, MDU, branches, reset.
module tb_ysyx_25040118_exu_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] pc, src1, src2, imm, inst;
    logic [4:0]  alu_ctrl;
    logic        is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_lui;
    logic        is_alu_imm, is_mdu, ebreak;
    logic [2:0]  mdu_op;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_next_pc;
    logic        out_ebreak, out_misalign;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    ysyx_25040118_exu_mc dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .src1(src1), .src2(src2), .imm(imm), .inst(inst),
        .alu_ctrl(alu_ctrl),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .is_auipc(is_auipc), .is_lui(is_lui),
        .is_alu_imm(is_alu_imm), .is_mdu(is_mdu), .ebreak(ebreak),
        .mdu_op(mdu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_next_pc(out_next_pc),
        .out_ebreak(out_ebreak), .out_misalign(out_misalign),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        {is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_lui} = '0;
        {is_alu_imm, is_mdu, ebreak} = '0;
        alu_ctrl = '0;
        mdu_op   = '0;
        inst     = '0;
    endtask

    function automatic logic [31:0] f3i(input logic [2:0] f);
        return {17'b0, f, 12'b0};
    endfunction

    // Accept edge counts as latency 1.
    task automatic issue();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 1;
        while (!out_valid && l < 100) begin
            tick();
            l++;
        end
    endtask

    task automatic run_mdu(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int l;
        clear_ops();
        is_mdu = 1'b1; mdu_op = op; src1 = a; src2 = b;
        issue();
        wait_done(l);
        check_val({tag, "_lat"}, l, 33);
        check_val(tag, out_result, exp);
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        pc = 32'h8000_0000; src1 = '0; src2 = '0; imm = '0;
        clear_ops();
        tick(); tick();
        rst = 1'b0;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_req_valid", mem_req_valid, 0);
        check_val("rst_outs", {out_result | out_next_pc | mem_req_addr | mem_req_wdata}, 0);
        check_val("rst_flags", {mem_req_wmask, mem_req_we, out_ebreak, out_misalign}, 0);

        // back-to-back addi
        is_alu_imm = 1'b1; src1 = 32'd5; imm = -32'sd7;
        issue();
        check_val("addi_valid", out_valid, 1);
        check_val("addi_res", out_result, 32'hFFFF_FFFE);
        check_val("addi_npc", out_next_pc, 32'h8000_0004);
        check_val("addi_in_ready_busy", in_ready, 0);
        src1 = 32'h10; imm = 32'h20;
        tick();
        check_val("addi_in_ready_again", in_ready, 1);
        issue();
        check_val("addi2_res", out_result, 32'h30);
        tick();

        // sra register form
        clear_ops(); alu_ctrl = 5'b00110; src1 = 32'h8000_0000; src2 = 32'd4;
        issue();
        check_val("sra_res", out_result, 32'hF800_0000);
        tick();

        // lb with request and response stalls
        clear_ops(); is_load = 1'b1; inst = f3i(3'b000); src1 = 32'h8000_0000; imm = 32'd3;
        issue();
        check_val("lb_req_valid", mem_req_valid, 1);
        check_val("lb_req_addr", mem_req_addr, 32'h3);
        check_val("lb_req_we", mem_req_we, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("lb_req_hold", {mem_req_valid, mem_req_addr[30:0]}, {1'b1, 31'h3});
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check_val("lb_req_drop", mem_req_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("lb_rsp_wait", out_valid, 0);
        end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h80AA_BBCC;
        tick();
        mem_rsp_valid = 1'b0;
        check_val("lb_valid", out_valid, 1);
        check_val("lb_res", out_result, 32'hFFFF_FF80);
        tick();

        // lbu with zero-wait bus: req at N+1, result at N+3
        clear_ops(); is_load = 1'b1; inst = f3i(3'b100); src1 = 32'h8000_0000; imm = 32'd3;
        mem_req_ready = 1'b1;
        issue();
        check_val("lbu_req_n1", mem_req_valid, 1);
        tick();
        check_val("lbu_n2_valid", out_valid, 0);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check_val("lbu_n3_valid", out_valid, 1);
        check_val("lbu_res", out_result, 32'h0000_0080);
        tick();

        // sh at lane 2
        clear_ops(); is_store = 1'b1; inst = f3i(3'b001);
        src1 = 32'h8000_0100; imm = 32'd2; src2 = 32'h1234_5678;
        issue();
        check_val("sh_wmask", mem_req_wmask, 4'b1100);
        check_val("sh_wdata", mem_req_wdata, 32'h5678_0000);
        check_val("sh_we", mem_req_we, 1);
        check_val("sh_addr", mem_req_addr, 32'h102);
        tick();
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check_val("sh_done", {out_valid, out_misalign}, 2'b10);
        tick();
        mem_req_ready = 1'b0;

        // misaligned sw
        clear_ops(); is_store = 1'b1; inst = f3i(3'b010); pc = 32'h8000_0040;
        src1 = 32'h8000_0100; imm = 32'd1;
        issue();
        check_val("sw_mis_valid", out_valid, 1);
        check_val("sw_mis_flag", out_misalign, 1);
        check_val("sw_mis_noreq", mem_req_valid, 0);
        check_val("sw_mis_res", out_result, 0);
        check_val("sw_mis_npc", out_next_pc, 32'h8000_0044);
        tick();
        check_val("sw_mis_noreq2", mem_req_valid, 0);

        // MDU
        run_mdu("mulh", 3'd1, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
        run_mdu("div", 3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD);
        run_mdu("rem", 3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF);
        run_mdu("divu0", 3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_mdu("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_mdu("mul", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);

        // bge not taken, with out_ready backpressure
        clear_ops(); is_branch = 1'b1; inst = f3i(3'b101);
        src1 = 32'hFFFF_FFFF; src2 = 32'd0; pc = 32'h8000_0010; imm = 32'd8;
        out_ready = 1'b0;
        issue();
        for (int i = 0; i < 5; i++) begin
            check_val("bge_hold", {out_valid, in_ready, out_next_pc[29:0]}, {2'b10, 30'h14});
            tick();
        end
        out_ready = 1'b1;
        check_val("bge_npc", out_next_pc, 32'h8000_0014);
        tick();
        check_val("bge_in_ready", in_ready, 1);

        // blt taken
        inst = f3i(3'b100);
        issue();
        check_val("blt_npc", out_next_pc, 32'h8000_0018);
        tick();

        // jalr clears bit 0
        clear_ops(); is_jalr = 1'b1; pc = 32'h8000_0020; src1 = 32'h8000_0101; imm = 32'h10;
        issue();
        check_val("jalr_npc", out_next_pc, 32'h8000_0110);
        check_val("jalr_link", out_result, 32'h8000_0024);
        tick();

        // ebreak
        clear_ops(); ebreak = 1'b1;
        issue();
        check_val("ebreak_flag", out_ebreak, 1);
        check_val("ebreak_npc", out_next_pc, 32'h8000_0024);
        tick();

        // reset during MEM_WAIT, then a stray response
        clear_ops(); is_load = 1'b1; inst = f3i(3'b010); src1 = 32'h8000_0000; imm = 32'd4;
        mem_req_ready = 1'b1;
        issue();
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mrst_outs", {out_result | out_next_pc | mem_req_addr | mem_req_wdata}, 0);
        check_val("mrst_flags", {out_valid, mem_req_valid, out_ebreak, out_misalign, in_ready}, 5'b00001);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        check_val("mrst_stray", {out_valid, in_ready}, 2'b01);
        clear_ops(); is_lui = 1'b1; imm = 32'h1234_5000;
        issue();
        wait_done(lat);
        check_val("mrst_next_lat", lat, 1);
        check_val("mrst_next_res", out_result, 32'h1234_5000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
